// File: rtl/secure_serdes_pkg.sv
// Shared definitions for the secure serdes encryptor/decryptor pair:
// FSM encodings, byte and FIFO geometry, and the XOR cipher primitive.
package secure_serdes_pkg;

    localparam int BYTE_W     = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_DECRYPT = 2'd2;

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       LAST_BIT  = 3'd7;

    typedef logic [BYTE_W-1:0] byte_t;

    // The cipher is its own inverse: encrypt and decrypt are the same XOR.
    function automatic byte_t xor_cipher(input byte_t x, input byte_t y, input byte_t k);
        return x ^ y ^ k;
    endfunction

endpackage

// File: rtl/secure_serdes_byte_fifo.sv
// Two-entry byte FIFO with wrapping pointers; head data is always visible
// on head_data and stays put until popped.
module secure_serdes_byte_fifo
    import secure_serdes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  byte_t            push_data,
    input  logic             pop,
    output byte_t            head_data,
    output logic [CNT_W-1:0] count
);

    byte_t            mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_pop;
    logic             do_push;

    // Popping an empty FIFO is a no-op; a push into a full FIFO only lands
    // if the head leaves in the same cycle.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != FIFO_FULL) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/secure_serdes_decryptor_core.sv
// Serial XOR decryptor: shifts in 8 cipher and B bits MSB first, recovers
// A = C ^ B ^ key[7:0] and queues it in a two-byte output buffer.
module secure_serdes_decryptor_core
    import secure_serdes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       key,
    input  logic               cipher_in,
    input  logic               b_bit,
    output logic [BYTE_W-1:0]  plain_byte,
    output logic               plain_valid,
    input  logic               plain_ready,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    logic [1:0]        state_reg;
    byte_t             c_reg;
    byte_t             b_reg;
    byte_t             key_q_reg;
    logic [2:0]        bit_cnt_reg;
    logic              overflow_reg;

    logic [CNT_W-1:0]  fifo_count;
    byte_t             fifo_head;
    logic              push;
    logic              pop;
    logic              frame_slot;
    logic              has_room;
    logic              accept;
    logic              refuse;
    logic              key_hi_unused;

    assign key_hi_unused = ^key[127:BYTE_W];

    assign push = (state_reg == ST_DECRYPT);
    assign pop  = plain_valid && plain_ready;

    // A new frame may begin from IDLE or in the DECRYPT cycle itself, which
    // gives back-to-back frames every 9 cycles. In DECRYPT the byte being
    // pushed must leave room for the next frame's result.
    assign frame_slot = (state_reg == ST_IDLE) || (state_reg == ST_DECRYPT);

    always_comb begin
        has_room = 1'b0;
        case (state_reg)
            ST_IDLE:    has_room = (fifo_count != FIFO_FULL);
            ST_DECRYPT: has_room = (fifo_count == '0) || pop;
            default:    has_room = 1'b0;
        endcase
    end

    assign accept = start && frame_slot && has_room;
    assign refuse = start && frame_slot && !has_room;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            c_reg        <= '0;
            b_reg        <= '0;
            key_q_reg    <= '0;
            bit_cnt_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (refuse) begin
                overflow_reg <= 1'b1;
            end
            if (accept) begin
                state_reg   <= ST_SHIFT;
                c_reg       <= '0;
                b_reg       <= '0;
                bit_cnt_reg <= '0;
                key_q_reg   <= key[BYTE_W-1:0];
            end else begin
                case (state_reg)
                    ST_SHIFT: begin
                        c_reg       <= {c_reg[BYTE_W-2:0], cipher_in};
                        b_reg       <= {b_reg[BYTE_W-2:0], b_bit};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg <= ST_DECRYPT;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    secure_serdes_byte_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (xor_cipher(c_reg, b_reg, key_q_reg)),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign plain_byte  = fifo_head;
    assign plain_valid = (fifo_count != '0);
    assign busy        = (state_reg != ST_IDLE);
    assign done        = push;
    assign overflow    = overflow_reg;

endmodule
